dw_rowbuf_ctrl: RTL and testbench

Sequencer for the depthwise-convolution row buffer and window generator. Accepts a per-frame configuration (frame width/height), programs the row-buffer length through its length-control/reset pair, gates the pixel stream with a ready/valid handshake, tracks row/column position and flags the cycles on which the 3×3 window is complete. It sits between the layer scheduler and the DW row buffer in the DW-conv preprocessing path.

---
 rtl/dw_pkg.sv | 12 +
 rtl/dw_rowbuf_ctrl_if.sv | 40 ++++
 rtl/dw_pos_cnt.sv | 51 +++++
 rtl/dw_rowbuf_ctrl.sv | 157 +++++++++++++++
 tb/tb_dw_rowbuf_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/dw_pkg.sv
// Shared types and defaults for the depthwise-conv row-buffer sequencer.
package dw_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } dw_state_e;

  localparam int DW_WIN_K      = 3;
  localparam int DW_MAX_WIDTH  = 320;
  localparam int DW_MAX_HEIGHT = 240;
endpackage

// File: rtl/dw_rowbuf_ctrl_if.sv
// Scheduler <-> row-buffer controller bundle. DW_STRIDE2_EN adds cfg_stride2.
interface dw_rowbuf_ctrl_if #(
  parameter int W_W = 9,
  parameter int H_W = 8
);
  logic           cfg_start;
  logic [W_W-1:0] cfg_width;
  logic [H_W-1:0] cfg_height;
`ifdef DW_STRIDE2_EN
  logic           cfg_stride2;
`endif
  logic           cfg_err;
  logic           pix_valid;
  logic           pix_ready;
  logic [W_W-1:0] rb_len;
  logic           rb_len_rst;
  logic           win_valid;
  logic [H_W-1:0] win_row;
  logic [W_W-1:0] win_col;
  logic           busy;
  logic           frame_done;

  modport master (
    output cfg_start, cfg_width, cfg_height, pix_valid,
`ifdef DW_STRIDE2_EN
    output cfg_stride2,
`endif
    input  cfg_err, pix_ready, rb_len, rb_len_rst, win_valid, win_row, win_col,
    input  busy, frame_done
  );

  modport slave (
    input  cfg_start, cfg_width, cfg_height, pix_valid,
`ifdef DW_STRIDE2_EN
    input  cfg_stride2,
`endif
    output cfg_err, pix_ready, rb_len, rb_len_rst, win_valid, win_row, win_col,
    output busy, frame_done
  );
endinterface

// File: rtl/dw_pos_cnt.sv
// Row/column position counter; wraps at the latched frame size, flags the last pixel.
module dw_pos_cnt #(
  parameter int W_W = 9,
  parameter int H_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [W_W-1:0] width,
  input  logic [H_W-1:0] height,
  output logic [H_W-1:0] row,
  output logic [W_W-1:0] col,
  output logic           last
);
  logic [H_W-1:0] row_q, row_d;
  logic [W_W-1:0] col_q, col_d;
  logic           col_end, row_end;

  assign col_end = (col_q == width - W_W'(1));
  assign row_end = (row_q == height - H_W'(1));
  assign last    = col_end && row_end;
  assign row     = row_q;
  assign col     = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + H_W'(1);
      end else begin
        col_d = col_q + W_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/dw_rowbuf_ctrl.sv
// DW row-buffer sequencer: config check, row-buffer length load, pixel gating, 3x3 window flags.
// Optional DW_STRIDE2_EN restricts windows to even row/column positions when cfg_stride2=1.
module dw_rowbuf_ctrl
  import dw_pkg::*;
#(
  parameter int MAX_WIDTH  = DW_MAX_WIDTH,
  parameter int MAX_HEIGHT = DW_MAX_HEIGHT,
  parameter int W_W        = $clog2(MAX_WIDTH + 1),
  parameter int H_W        = $clog2(MAX_HEIGHT + 1)
) (
  input logic             clk,
  input logic             rst,
  dw_rowbuf_ctrl_if.slave bus
);
  localparam logic [W_W-1:0] W_MIN = W_W'(DW_WIN_K);
  localparam logic [H_W-1:0] H_MIN = H_W'(DW_WIN_K);
  localparam logic [W_W-1:0] W_MAX = W_W'(MAX_WIDTH);
  localparam logic [H_W-1:0] H_MAX = H_W'(MAX_HEIGHT);

  dw_state_e      state_q, state_d;
  logic [W_W-1:0] width_q, width_d, rb_len_q, rb_len_d, win_col_q, win_col_d;
  logic [H_W-1:0] height_q, height_d, win_row_q, win_row_d;
  logic           rb_len_rst_q, rb_len_rst_d, pix_ready_q, pix_ready_d;
  logic           win_valid_q, win_valid_d, busy_q, busy_d;
  logic           frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;
  logic [H_W-1:0] cnt_row;
  logic [W_W-1:0] cnt_col;
  logic           cnt_last, cnt_clr, accept, cfg_ok, win_hit;
`ifdef DW_STRIDE2_EN
  logic           stride2_q, stride2_d;
`endif

  assign accept = pix_ready_q && bus.pix_valid;
  assign cfg_ok = (bus.cfg_width >= W_MIN) && (bus.cfg_width <= W_MAX) &&
                  (bus.cfg_height >= H_MIN) && (bus.cfg_height <= H_MAX);

  // Top-left K-1 rows/cols are edge fill; the window is complete from (K-1,K-1) on.
`ifdef DW_STRIDE2_EN
  assign win_hit = (cnt_row >= H_W'(DW_WIN_K - 1)) && (cnt_col >= W_W'(DW_WIN_K - 1)) &&
                   (!stride2_q || (!cnt_row[0] && !cnt_col[0]));
`else
  assign win_hit = (cnt_row >= H_W'(DW_WIN_K - 1)) && (cnt_col >= W_W'(DW_WIN_K - 1));
`endif

  dw_pos_cnt #(.W_W(W_W), .H_W(H_W)) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (accept),
    .width  (width_q),
    .height (height_q),
    .row    (cnt_row),
    .col    (cnt_col),
    .last   (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    rb_len_d     = rb_len_q;
    rb_len_rst_d = 1'b0;
    pix_ready_d  = pix_ready_q;
    win_valid_d  = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    cnt_clr      = 1'b0;
`ifdef DW_STRIDE2_EN
    stride2_d    = stride2_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.cfg_start) begin
        if (cfg_ok) begin
          state_d      = ST_LOAD;
          width_d      = bus.cfg_width;
          height_d     = bus.cfg_height;
          rb_len_d     = bus.cfg_width - W_W'(DW_WIN_K - 1);
          rb_len_rst_d = 1'b1;
          busy_d       = 1'b1;
          cnt_clr      = 1'b1;
`ifdef DW_STRIDE2_EN
          stride2_d    = bus.cfg_stride2;
`endif
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d     = ST_STREAM;
        pix_ready_d = 1'b1;
      end
      ST_STREAM: if (accept) begin
        if (win_hit) begin
          win_valid_d = 1'b1;
          win_row_d   = cnt_row;
          win_col_d   = cnt_col;
        end
        if (cnt_last) begin
          state_d      = ST_IDLE;
          pix_ready_d  = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      rb_len_q     <= W_W'(MAX_WIDTH - (DW_WIN_K - 1));
      rb_len_rst_q <= 1'b0;
      pix_ready_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef DW_STRIDE2_EN
      stride2_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      rb_len_q     <= rb_len_d;
      rb_len_rst_q <= rb_len_rst_d;
      pix_ready_q  <= pix_ready_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
`ifdef DW_STRIDE2_EN
      stride2_q    <= stride2_d;
`endif
    end
  end

  assign bus.cfg_err    = cfg_err_q;
  assign bus.pix_ready  = pix_ready_q;
  assign bus.rb_len     = rb_len_q;
  assign bus.rb_len_rst = rb_len_rst_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dw_rowbuf_ctrl.sv
// Directed bench for dw_rowbuf_ctrl; define DW_STRIDE2_EN to also cover the stride-2 window mask.
module tb_dw_rowbuf_ctrl;
  logic clk, rst;
  int checks = 0, failures = 0;
  int win_r[16], win_c[16];
  int nwin, acc_cnt, done_seen, done_acc, done_cyc, viol;
  logic       ld_rst, ld_busy, ld_ready, ld_done, st_ready, st_rst;
  logic [8:0] ld_len;

  dw_rowbuf_ctrl_if #(.W_W(9), .H_W(8)) bus ();
  dw_rowbuf_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives cfg_start for one cycle and snapshots the LOAD cycle and first STREAM cycle.
  task automatic start_frame(input int w, input int h);
    bus.cfg_start = 1'b1; bus.cfg_width = 9'(w); bus.cfg_height = 8'(h);
    tick;
    bus.cfg_start = 1'b0;
    ld_rst = bus.rb_len_rst; ld_len = bus.rb_len; ld_busy = bus.busy;
    ld_ready = bus.pix_ready; ld_done = bus.frame_done;
    tick;
    st_ready = bus.pix_ready; st_rst = bus.rb_len_rst;
  endtask

  // Streams pixels until frame_done (bounded), recording windows and any activity on non-accept cycles.
  task automatic run_frame(input int stall, input int poke);
    int cyc; logic acc; logic [7:0] pr; logic [8:0] pc;
    nwin = 0; acc_cnt = 0; done_seen = 0; done_acc = -1; done_cyc = -1; viol = 0; cyc = 0;
    pr = bus.win_row; pc = bus.win_col;
    while (done_seen == 0 && cyc < 200) begin
      bus.pix_valid = (stall != 0) ? (cyc % 2 == 0) : 1'b1;
      if (cyc == poke) begin bus.cfg_start = 1'b1; bus.cfg_width = 9'd8; bus.cfg_height = 8'd6; end
      acc = bus.pix_valid && bus.pix_ready;
      tick;
      bus.cfg_start = 1'b0;
      if (acc) acc_cnt++;
      if (bus.cfg_err || bus.rb_len_rst) viol++;
      if (!acc && (bus.win_valid || bus.frame_done || bus.win_row !== pr || bus.win_col !== pc)) viol++;
      if (bus.win_valid) begin
        if (nwin < 16) begin win_r[nwin] = int'(bus.win_row); win_c[nwin] = int'(bus.win_col); end
        nwin++;
      end
      if (bus.frame_done) begin done_seen = 1; done_acc = acc ? acc_cnt : -1; done_cyc = cyc + 1; end
      pr = bus.win_row; pc = bus.win_col;
      cyc++;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.cfg_start = 1'b0; bus.cfg_width = '0; bus.cfg_height = '0; bus.pix_valid = 1'b0;
`ifdef DW_STRIDE2_EN
    bus.cfg_stride2 = 1'b0;
`endif
    tick; tick;
    checks++; if (bus.pix_ready !== 1'b0) begin failures++; $display("FAIL rst_pix_ready got=%0d exp=0", bus.pix_ready); end
    checks++; if (bus.rb_len !== 9'd318) begin failures++; $display("FAIL rst_rb_len got=%0d exp=318", bus.rb_len); end
    checks++; if (bus.rb_len_rst !== 1'b0) begin failures++; $display("FAIL rst_rb_len_rst got=%0d exp=0", bus.rb_len_rst); end
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL rst_win_valid got=%0d exp=0", bus.win_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0 || bus.cfg_err !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%0d/%0d exp=0/0", bus.frame_done, bus.cfg_err); end
    checks++; if (bus.win_row !== 8'd0 || bus.win_col !== 9'd0) begin failures++; $display("FAIL rst_win_pos got=%0d,%0d exp=0,0", bus.win_row, bus.win_col); end
    rst = 1'b0;
  endtask

  task automatic test_frame_basic;
    int er[6] = '{2, 2, 2, 3, 3, 3};
    int ec[6] = '{2, 3, 4, 2, 3, 4};
    start_frame(5, 4);
    checks++; if (ld_rst !== 1'b1 || ld_len !== 9'd3) begin failures++; $display("FAIL basic_load got rst=%0d len=%0d exp rst=1 len=3", ld_rst, ld_len); end
    checks++; if (ld_busy !== 1'b1 || ld_ready !== 1'b0) begin failures++; $display("FAIL basic_load_busy got busy=%0d rdy=%0d exp 1/0", ld_busy, ld_ready); end
    checks++; if (st_ready !== 1'b1 || st_rst !== 1'b0) begin failures++; $display("FAIL basic_stream got rdy=%0d rst=%0d exp 1/0", st_ready, st_rst); end
    run_frame(0, -1);
    checks++; if (done_seen !== 1 || done_acc !== 20 || done_cyc !== 20) begin failures++; $display("FAIL basic_done got seen=%0d acc=%0d cyc=%0d exp 1/20/20", done_seen, done_acc, done_cyc); end
    checks++; if (nwin !== 6) begin failures++; $display("FAIL basic_nwin got=%0d exp=6", nwin); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (win_r[i] !== er[i] || win_c[i] !== ec[i]) begin failures++; $display("FAIL basic_win%0d got=(%0d,%0d) exp=(%0d,%0d)", i, win_r[i], win_c[i], er[i], ec[i]); end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL basic_quiet got=%0d exp=0", viol); end
    checks++; if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin failures++; $display("FAIL basic_idle got busy=%0d rdy=%0d exp 0/0", bus.busy, bus.pix_ready); end
  endtask

  // Restarts on the very cycle frame_done is visible, then streams with pix_valid toggling.
  task automatic test_back_to_back;
    int er[6] = '{2, 2, 2, 3, 3, 3};
    int ec[6] = '{2, 3, 4, 2, 3, 4};
    start_frame(5, 4);
    checks++; if (ld_rst !== 1'b1 || ld_done !== 1'b0) begin failures++; $display("FAIL b2b_load got rst=%0d done=%0d exp 1/0", ld_rst, ld_done); end
    run_frame(1, -1);
    checks++; if (done_seen !== 1 || done_acc !== 20 || done_cyc !== 39) begin failures++; $display("FAIL stall_done got seen=%0d acc=%0d cyc=%0d exp 1/20/39", done_seen, done_acc, done_cyc); end
    checks++; if (nwin !== 6) begin failures++; $display("FAIL stall_nwin got=%0d exp=6", nwin); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (win_r[i] !== er[i] || win_c[i] !== ec[i]) begin failures++; $display("FAIL stall_win%0d got=(%0d,%0d) exp=(%0d,%0d)", i, win_r[i], win_c[i], er[i], ec[i]); end
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL stall_frozen got=%0d exp=0", viol); end
    tick;
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL stall_done_pulse got=%0d exp=0", bus.frame_done); end
  endtask

  task automatic test_cfg_err;
    int bw[3] = '{2, 5, 321};
    int bh[3] = '{4, 241, 4};
    for (int i = 0; i < 3; i++) begin
      bus.cfg_start = 1'b1; bus.cfg_width = 9'(bw[i]); bus.cfg_height = 8'(bh[i]);
      tick;
      bus.cfg_start = 1'b0;
      checks++; if (bus.cfg_err !== 1'b1) begin failures++; $display("FAIL cfgerr%0d_pulse got=%0d exp=1", i, bus.cfg_err); end
      checks++; if (bus.busy !== 1'b0 || bus.rb_len_rst !== 1'b0 || bus.rb_len !== 9'd3) begin failures++; $display("FAIL cfgerr%0d_state got busy=%0d rst=%0d len=%0d exp 0/0/3", i, bus.busy, bus.rb_len_rst, bus.rb_len); end
      tick;
      checks++; if (bus.cfg_err !== 1'b0 || bus.rb_len_rst !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL cfgerr%0d_after got err=%0d rst=%0d busy=%0d exp 0/0/0", i, bus.cfg_err, bus.rb_len_rst, bus.busy); end
    end
  endtask

  task automatic test_cfg_ignore;
    start_frame(5, 4);
    run_frame(0, 3);
    checks++; if (done_seen !== 1 || done_acc !== 20) begin failures++; $display("FAIL ignore_done got seen=%0d acc=%0d exp 1/20", done_seen, done_acc); end
    checks++; if (nwin !== 6 || viol !== 0) begin failures++; $display("FAIL ignore_win got nwin=%0d viol=%0d exp 6/0", nwin, viol); end
    checks++; if (bus.rb_len !== 9'd3) begin failures++; $display("FAIL ignore_rb_len got=%0d exp=3", bus.rb_len); end
  endtask

  task automatic test_rst_midframe;
    start_frame(5, 4);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    bus.pix_valid = 1'b0; rst = 1'b1;
    tick;
    checks++; if (bus.pix_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rb_len_rst !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl got rdy=%0d busy=%0d rst=%0d exp 0/0/0", bus.pix_ready, bus.busy, bus.rb_len_rst); end
    checks++; if (bus.rb_len !== 9'd318 || bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin failures++; $display("FAIL mid_rst_out got len=%0d wv=%0d fd=%0d exp 318/0/0", bus.rb_len, bus.win_valid, bus.frame_done); end
    rst = 1'b0;
    start_frame(6, 3);
    checks++; if (ld_rst !== 1'b1 || ld_len !== 9'd4) begin failures++; $display("FAIL mid_load got rst=%0d len=%0d exp 1/4", ld_rst, ld_len); end
    run_frame(0, -1);
    checks++; if (done_seen !== 1 || done_acc !== 18 || nwin !== 4) begin failures++; $display("FAIL mid_frame got seen=%0d acc=%0d nwin=%0d exp 1/18/4", done_seen, done_acc, nwin); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (win_r[i] !== 2 || win_c[i] !== i + 2) begin failures++; $display("FAIL mid_win%0d got=(%0d,%0d) exp=(2,%0d)", i, win_r[i], win_c[i], i + 2); end
    end
  endtask

  task automatic test_min_frame;
    start_frame(3, 3);
    checks++; if (ld_len !== 9'd1) begin failures++; $display("FAIL min_rb_len got=%0d exp=1", ld_len); end
    run_frame(0, -1);
    checks++; if (done_acc !== 9 || nwin !== 1 || win_r[0] !== 2 || win_c[0] !== 2) begin failures++; $display("FAIL min_frame got acc=%0d nwin=%0d w=(%0d,%0d) exp 9/1/(2,2)", done_acc, nwin, win_r[0], win_c[0]); end
  endtask

`ifdef DW_STRIDE2_EN
  task automatic test_stride2;
    int er[4] = '{2, 2, 4, 4};
    int ec[4] = '{2, 4, 2, 4};
    bus.cfg_stride2 = 1'b1;
    start_frame(6, 6);
    bus.cfg_stride2 = 1'b0;
    run_frame(0, -1);
    checks++; if (done_acc !== 36 || nwin !== 4) begin failures++; $display("FAIL s2_frame got acc=%0d nwin=%0d exp 36/4", done_acc, nwin); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (win_r[i] !== er[i] || win_c[i] !== ec[i]) begin failures++; $display("FAIL s2_win%0d got=(%0d,%0d) exp=(%0d,%0d)", i, win_r[i], win_c[i], er[i], ec[i]); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_frame_basic;
    test_back_to_back;
    test_cfg_err;
    test_cfg_ignore;
    test_rst_midframe;
    test_min_frame;
`ifdef DW_STRIDE2_EN
    test_stride2;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
